// File: rtl/common_pkg.sv
// Shared bus-level definitions: datapath width, access sizes, dbus request/response
// layouts and the per-size byte-mask helpers used by load/store alignment.
package common_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [STRB_W-1:0] strobe_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    localparam strobe_t MASK1 = 8'h01;
    localparam strobe_t MASK2 = 8'h03;
    localparam strobe_t MASK4 = 8'h0F;
    localparam strobe_t MASK8 = 8'hFF;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    function automatic strobe_t size_mask(input msize_t size);
        case (size)
            MSIZE1:  return MASK1;
            MSIZE2:  return MASK2;
            MSIZE4:  return MASK4;
            default: return MASK8;
        endcase
    endfunction

    // An access is aligned when the low address bits below its size are all zero.
    function automatic logic misaligned(input logic [2:0] addr_lo, input msize_t size);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return addr_lo[0];
            MSIZE4:  return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline register layouts around the MEM stage and the MEM-stage FSM state encoding.
package pipes_pkg;

    import common_pkg::*;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic   mem_read;
        logic   mem_write;
        msize_t msize;
        logic   mem_unsigned;
    } mem_ctl_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        word_t    alu;
        word_t    rs2;
        mem_ctl_t ctl;
        reg_idx_t rd;
        logic     regwrite;
    } execute_data_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        reg_idx_t rd;
        logic     regwrite;
        word_t    wb;
        logic     misalign;
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between a 64-bit aligned data bus and register values:
// store strobe/data placement and load extraction with sign/zero extension.
module mem_align
    import common_pkg::*;
(
    input  logic [2:0] addr_lo,
    input  msize_t     msize,
    input  logic       is_unsigned,
    input  word_t      store_data,
    input  word_t      load_raw,
    output strobe_t    strobe,
    output word_t      store_lane,
    output word_t      load_value
);

    logic [5:0] shamt;
    word_t      raw;

    assign shamt      = {addr_lo, 3'b000};
    assign raw        = load_raw >> shamt;
    assign store_lane = store_data << shamt;
    assign strobe     = size_mask(msize) << addr_lo;

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of inferred latches.
        load_value = raw;
        case (msize)
            MSIZE1: load_value = is_unsigned ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                             : {{(XLEN-8){raw[7]}}, raw[7:0]};
            MSIZE2: load_value = is_unsigned ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                             : {{(XLEN-16){raw[15]}}, raw[15:0]};
            MSIZE4: load_value = is_unsigned ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                             : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: load_value = raw;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues dbus loads/stores, stalls while a request is outstanding,
// and keeps a once-issued request on the bus until it completes, even across a flush.
module memory_stage
    import pipes_pkg::*;
#(
    parameter int XLEN   = common_pkg::XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  execute_data_t       dataE,
    input  logic                advance,
    input  logic                flush,
    output logic                dreq_valid,
    output logic [XLEN-1:0]     dreq_addr,
    output common_pkg::msize_t  dreq_size,
    output logic [STRB_W-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_data,
    input  logic                dresp_data_ok,
    input  logic [XLEN-1:0]     dresp_data,
    output memory_data_t        dataM_nxt,
    output logic                mem_stall
);

    mem_state_t state, next_state;

    common_pkg::dbus_req_t req_now, req_q, req_out;
    memory_data_t          pass_result, resp_result, result_q;

    logic               is_mem, misalign_op, memop;
    logic               capture, issue;
    common_pkg::strobe_t align_strobe;
    common_pkg::word_t   store_lane, load_value;

    assign is_mem      = dataE.valid & (dataE.ctl.mem_read | dataE.ctl.mem_write);
    assign misalign_op = is_mem & common_pkg::misaligned(dataE.alu[2:0], dataE.ctl.msize);
    assign memop       = is_mem & ~misalign_op;

    mem_align u_align (
        .addr_lo     (dataE.alu[2:0]),
        .msize       (dataE.ctl.msize),
        .is_unsigned (dataE.ctl.mem_unsigned),
        .store_data  (dataE.rs2),
        .load_raw    (dresp_data),
        .strobe      (align_strobe),
        .store_lane  (store_lane),
        .load_value  (load_value)
    );

    always_comb begin
        req_now.valid  = 1'b1;
        req_now.addr   = dataE.alu;
        req_now.size   = dataE.ctl.msize;
        req_now.strobe = dataE.ctl.mem_write ? align_strobe : '0;
        req_now.data   = store_lane;
    end

    // Misaligned accesses pass straight through flagged, with the register write suppressed.
    always_comb begin
        pass_result.valid    = dataE.valid & ~flush;
        pass_result.pc       = dataE.pc;
        pass_result.rd       = dataE.rd;
        pass_result.regwrite = dataE.regwrite & ~misalign_op;
        pass_result.wb       = dataE.alu;
        pass_result.misalign = misalign_op;

        resp_result          = pass_result;
        resp_result.valid    = 1'b1;
        resp_result.regwrite = dataE.regwrite;
        resp_result.wb       = dataE.ctl.mem_read ? load_value : dataE.alu;
        resp_result.misalign = 1'b0;
    end

    always_comb begin
        next_state       = state;
        req_out          = req_now;
        req_out.valid    = 1'b0;
        mem_stall        = 1'b0;
        dataM_nxt        = pass_result;
        capture          = 1'b0;
        issue            = 1'b0;

        case (state)
            IDLE: begin
                if (!flush && memop) begin
                    req_out.valid = 1'b1;
                    mem_stall     = ~dresp_data_ok;
                    if (dresp_data_ok) begin
                        dataM_nxt = resp_result;
                        if (!advance) begin
                            capture    = 1'b1;
                            next_state = DONE;
                        end
                    end else begin
                        dataM_nxt.valid = 1'b0;
                        issue           = 1'b1;
                        next_state      = WAIT;
                    end
                end
            end
            WAIT: begin
                req_out.valid   = 1'b1;
                mem_stall       = ~dresp_data_ok;
                dataM_nxt.valid = 1'b0;
                if (dresp_data_ok) begin
                    if (flush) begin
                        next_state = IDLE;
                    end else begin
                        dataM_nxt = resp_result;
                        if (advance) begin
                            next_state = IDLE;
                        end else begin
                            capture    = 1'b1;
                            next_state = DONE;
                        end
                    end
                end else if (flush) begin
                    next_state = ABORT;
                end
            end
            DONE: begin
                dataM_nxt = result_q;
                if (flush) begin
                    dataM_nxt.valid = 1'b0;
                    next_state      = IDLE;
                end else if (advance) begin
                    next_state = IDLE;
                end
            end
            ABORT: begin
                // The killed instruction's fields may be gone from dataE; replay the saved request.
                req_out         = req_q;
                req_out.valid   = 1'b1;
                mem_stall       = 1'b1;
                dataM_nxt.valid = 1'b0;
                if (dresp_data_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign dreq_valid  = req_out.valid;
    assign dreq_addr   = req_out.addr;
    assign dreq_size   = req_out.size;
    assign dreq_strobe = req_out.strobe;
    assign dreq_data   = req_out.data;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state    <= IDLE;
            result_q <= '0;
            req_q    <= '0;
        end else begin
            state <= next_state;
            if (capture) result_q <= resp_result;
            if (issue)   req_q    <= req_now;
        end
    end

endmodule
